soc_system_gpio_in_edge_irq: RTL and testbench
==============================================

# soc_system_gpio_in_edge_irq

Parametrised Avalon-MM input-port peripheral for the HPS-to-FPGA lightweight bus, the next generation of the fixed 4-bit edge-capture GPIO inputs. Each of WIDTH inputs is synchronised and debounced, then independently watched for rising and/or falling edges. Captured edges are held in a write-1-to-clear register and can be masked onto a level interrupt line.

## Interface
- WIDTH, 4: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, ≥2.
- CNT_W, 16: debounce counter width, 1..31.
- DEBOUNCE_RST, 0: reset value of the DEBOUNCE register.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data, zero-extended; reset 0.
- irq  out  1  level interrupt; reset 0.

## Operation
- Register map, by address:
  - 0 DATA: RO, debounced value.
  - 1 RISE_EN: RW, WIDTH bits.
  - 2 IRQ_MASK: RW, WIDTH bits.
  - 3 EDGE_CAPTURE: read returns the captured bits; a write clears each bit written as 1 (W1C).
  - 4 FALL_EN: RW, WIDTH bits.
  - 5 DEBOUNCE: RW, CNT_W bits.
  - 6 RAW: RO, synchronised value before debounce.
  - 7: reads 0; writes are ignored.
- Reset values: every register is 0, except DEBOUNCE, which resets to DEBOUNCE_RST. The synchroniser, stable and previous-stable flops also reset to 0.
- Write strobe: chipselect && !write_n. Writes to RO addresses have no effect.
- Debounce, per bit, on sync (last synchroniser stage) vs stable:
  - While sync == stable, the counter holds at 0.
  - While they differ, the counter increments each cycle.
  - When they differ and cnt ≥ max(DEBOUNCE,1)−1, stable takes sync and the counter clears.
  - DEBOUNCE values 0 and 1 are equivalent: stable follows sync one cycle later.
  - A glitch shorter than DEBOUNCE cycles returns the counter to 0 and never reaches stable.
- Any write to DEBOUNCE clears all counters in the same clock edge.
- Edge detection: rise = stable & ~stable_d; fall = ~stable & stable_d.
- Capture: a bit sets when (rise & RISE_EN) | (fall & FALL_EN) is true for that bit.
- Capture and clear in the same cycle on the same bit: set wins, so no edge is lost. Other bits are unaffected.
- Capture is independent of IRQ_MASK; the mask only gates irq.
- irq = |(EDGE_CAPTURE & IRQ_MASK), computed combinationally from registers with no added flop.
- Reset release with an input held at 1: stable rises from 0, producing a rising edge. It is captured only if RISE_EN is already set, which it is not at reset.

## Timing
- Input to DATA: an in_port change is visible in stable after SYNC_STAGES + max(DEBOUNCE,1) clocks, given the input holds steady throughout.
- EDGE_CAPTURE sets 1 clock after stable changes. irq is asserted in that same cycle.
- Read latency is 1: readdata is registered from the address-selected mux every cycle, regardless of chipselect.
- Write effects are visible on the next read of any address. A W1C clear drops irq 1 clock after the write edge.
- Asynchronous reset mid-operation clears all state immediately, including any pending capture and irq.

## Structure
- Package soc_system_gpio_pkg holds the address constants (ADDR_DATA … ADDR_RAW) and the 3-bit address typedef.
- Sub-module soc_system_gpio_debounce: one bit, containing the synchroniser, counter, stable and stable_d, plus a counter-clear input. It is instantiated WIDTH times via generate.
- The top level holds the register file, capture logic, read mux and irq.

## Test plan
- Rising-edge capture: WIDTH=4, DEBOUNCE=0, RISE_EN=0x1, IRQ_MASK=0x1; drive in_port 0→0x1. Required: EDGE_CAPTURE=0x1 and irq=1 at 4 clocks. Write 0x1 to address 3 → irq=0 the next clock.
- Falling-edge filter: FALL_EN=0x2; pulse bit 1 high then low. Required: no capture on the rise, EDGE_CAPTURE=0x2 after the fall.
- Debounce: DEBOUNCE=10. A 9-cycle glitch leaves DATA and EDGE_CAPTURE at 0, with RAW briefly showing 1. A 10-cycle hold updates DATA at SYNC_STAGES+10 clocks.
- Simultaneous events: a W1C on bit 0 in the same cycle a new edge arrives on bit 0 → bit 0 stays 1. A concurrent W1C of bit 2 clears only bit 2.
- Masking: capture on bit 3 with IRQ_MASK=0 → irq=0, EDGE_CAPTURE=0x8. Then write IRQ_MASK=0x8 → irq=1 the next clock.
- Reset and width: assert reset_n mid-debounce with capture pending → all reads 0 and irq=0. Repeat the first scenario with WIDTH=32 on bit 31 → readdata=0x80000000.

Source files
------------

// File: rtl/soc_system_gpio_pkg.sv
// rtl/soc_system_gpio_pkg.sv - register map constants for the edge-capture GPIO input port
package soc_system_gpio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA     = 3'd0;
    localparam addr_t ADDR_RISE_EN  = 3'd1;
    localparam addr_t ADDR_IRQ_MASK = 3'd2;
    localparam addr_t ADDR_EDGE_CAP = 3'd3;
    localparam addr_t ADDR_FALL_EN  = 3'd4;
    localparam addr_t ADDR_DEBOUNCE = 3'd5;
    localparam addr_t ADDR_RAW      = 3'd6;

endpackage

// File: rtl/soc_system_gpio_debounce.sv
// rtl/soc_system_gpio_debounce.sv - one-bit synchroniser, debounce counter and edge history
module soc_system_gpio_debounce
    import soc_system_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             cnt_clr_i,
    output logic             sync_o,
    output logic             stable_o,
    output logic             stable_d_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q;

    assign sync_o     = sync_q[SYNC_STAGES-1];
    assign stable_o   = stable_q;
    assign stable_d_o = prev_q;

    // thresh_i is max(DEBOUNCE,1)-1, so stable moves after that many extra cycles of disagreement
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (sync_o == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= thresh_i) begin
            stable_d = sync_o;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

endmodule

// File: rtl/soc_system_gpio_in_edge_irq.sv
// rtl/soc_system_gpio_in_edge_irq.sv - debounced GPIO input port with W1C edge capture and masked irq
module soc_system_gpio_in_edge_irq
    import soc_system_gpio_pkg::*;
#(
    parameter int          WIDTH        = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter int          CNT_W        = 16,
    parameter int unsigned DEBOUNCE_RST = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw, stable, prev;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] thresh;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] cap_set, cap_clr;
    logic             wr, deb_wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr           = chipselect && !write_n;
    assign deb_wr       = wr && (address == ADDR_DEBOUNCE);
    assign thresh       = (deb_q == '0) ? '0 : deb_q - CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_system_gpio_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk_i     (clk),
            .rst_n_i   (reset_n),
            .in_i      (in_port[i]),
            .thresh_i  (thresh),
            .cnt_clr_i (deb_wr),
            .sync_o    (raw[i]),
            .stable_o  (stable[i]),
            .stable_d_o(prev[i])
        );
    end

    // set is OR-ed in after the clear so an edge coinciding with a W1C is kept
    assign cap_set = ((stable & ~prev) & rise_en_q) | ((~stable & prev) & fall_en_q);
    assign cap_clr = (wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;
    assign cap_d   = (cap_q & ~cap_clr) | cap_set;

    always_comb begin
        rise_en_d = rise_en_q;
        mask_d    = mask_q;
        fall_en_d = fall_en_q;
        deb_d     = deb_q;
        if (wr) begin
            case (address)
                ADDR_RISE_EN:  rise_en_d = writedata[WIDTH-1:0];
                ADDR_IRQ_MASK: mask_d    = writedata[WIDTH-1:0];
                ADDR_FALL_EN:  fall_en_d = writedata[WIDTH-1:0];
                ADDR_DEBOUNCE: deb_d     = writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = stable;
            ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
            ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_DEBOUNCE: readdata_d[CNT_W-1:0] = deb_q;
            ADDR_RAW:      readdata_d[WIDTH-1:0] = raw;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q  <= '0;
            mask_q     <= '0;
            fall_en_q  <= '0;
            cap_q      <= '0;
            deb_q      <= CNT_W'(DEBOUNCE_RST);
            readdata_q <= '0;
        end else begin
            rise_en_q  <= rise_en_d;
            mask_q     <= mask_d;
            fall_en_q  <= fall_en_d;
            cap_q      <= cap_d;
            deb_q      <= deb_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_system_gpio_in_edge_irq.sv
// tb/tb_soc_system_gpio_in_edge_irq.sv - vector table plus scoreboarded reads for the GPIO edge-irq port
module tb_soc_system_gpio_in_edge_irq;

    localparam int K_WR = 0, K_RD = 1, K_IN = 2, K_WAIT = 3, K_IRQ = 4;

    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        cs4 = 1'b0, cs32 = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in4 = '0;
    logic [31:0] in32 = '0;
    logic [31:0] rd4, rd32;
    logic        irq4, irq32;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    soc_system_gpio_in_edge_irq #(.WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
        .write_n(write_n), .writedata(writedata), .in_port(in4),
        .readdata(rd4), .irq(irq4)
    );

    soc_system_gpio_in_edge_irq #(.WIDTH(32), .DEBOUNCE_RST(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .in_port(in32),
        .readdata(rd32), .irq(irq32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs4       = (sel == 0);
        cs32      = (sel == 1);
        tick();
        write_n   = 1'b1;
        cs4       = 1'b0;
        cs32      = 1'b0;
    endtask

    task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        address = a;
        sb.push_back('{sel, exp, name});
        tick();
        e = sb.pop_front();
        check(e.name, (e.sel == 1) ? rd32 : rd4, e.exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{K_RD, 3'd0, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd1, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd2, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd3, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd4, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd5, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd6, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd7, 32'd0, 32'd0});
        vecs.push_back('{K_IRQ, 3'd0, 32'd0, 32'd0});
        vecs.push_back('{K_WR, 3'd1, 32'h1, 32'd0});
        vecs.push_back('{K_WR, 3'd2, 32'hFFFF_FFF1, 32'd0});
        vecs.push_back('{K_WR, 3'd7, 32'hFF, 32'd0});
        vecs.push_back('{K_WR, 3'd0, 32'hF, 32'd0});
        vecs.push_back('{K_RD, 3'd1, 32'd0, 32'h1});
        vecs.push_back('{K_RD, 3'd2, 32'd0, 32'h1});
        vecs.push_back('{K_RD, 3'd7, 32'd0, 32'h0});
        vecs.push_back('{K_RD, 3'd0, 32'd0, 32'h0});
        vecs.push_back('{K_IN, 3'd0, 32'h1, 32'd0});
        vecs.push_back('{K_WAIT, 3'd0, 32'd3, 32'd0});
        vecs.push_back('{K_IRQ, 3'd0, 32'd0, 32'd0});
        vecs.push_back('{K_WAIT, 3'd0, 32'd1, 32'd0});
        vecs.push_back('{K_IRQ, 3'd0, 32'd0, 32'd1});
        vecs.push_back('{K_RD, 3'd3, 32'd0, 32'h1});
        vecs.push_back('{K_RD, 3'd0, 32'd0, 32'h1});
        vecs.push_back('{K_WR, 3'd3, 32'h1, 32'd0});
        vecs.push_back('{K_IRQ, 3'd0, 32'd0, 32'd0});
        vecs.push_back('{K_RD, 3'd3, 32'd0, 32'h0});

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                K_WR:   wr(0, vecs[i].addr, vecs[i].data);
                K_RD:   rd(0, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd%0d", i, vecs[i].addr));
                K_IN:   in4 = vecs[i].data[3:0];
                K_WAIT: repeat (vecs[i].data) tick();
                default: check($sformatf("vec%0d_irq", i), {31'd0, irq4}, vecs[i].exp);
            endcase
        end

        // falling-edge filter on bit 1
        wr(0, 3'd4, 32'h2);
        rd(0, 3'd4, 32'h2, "fall_en_rb");
        in4 = 4'h3;
        repeat (6) tick();
        rd(0, 3'd3, 32'h0, "fall_no_rise_cap");
        in4 = 4'h1;
        repeat (6) tick();
        rd(0, 3'd3, 32'h2, "fall_cap");
        check("fall_irq_masked", {31'd0, irq4}, 32'd0);
        wr(0, 3'd3, 32'hF);
        rd(0, 3'd3, 32'h0, "fall_cleared");

        // debounce = 10: 9-cycle glitch on bit 2 is rejected, 10-cycle hold lands
        wr(0, 3'd5, 32'd10);
        rd(0, 3'd5, 32'd10, "deb_rb");
        wr(0, 3'd1, 32'h5);
        in4 = 4'h5;
        tick();
        tick();
        rd(0, 3'd6, 32'h5, "glitch_raw");
        repeat (6) tick();
        in4 = 4'h1;
        repeat (20) tick();
        rd(0, 3'd0, 32'h1, "glitch_data");
        rd(0, 3'd3, 32'h0, "glitch_cap");
        in4 = 4'h5;
        repeat (11) tick();
        rd(0, 3'd0, 32'h1, "hold_data_early");
        rd(0, 3'd0, 32'h5, "hold_data_on_time");
        rd(0, 3'd3, 32'h4, "hold_cap");
        wr(0, 3'd3, 32'h4);
        wr(0, 3'd5, 32'd0);

        // W1C racing a new edge on bit 0, while bit 2 is cleared alongside
        in4 = 4'h1;
        repeat (5) tick();
        in4 = 4'h5;
        repeat (5) tick();
        in4 = 4'h4;
        repeat (5) tick();
        rd(0, 3'd3, 32'h4, "race_pre_cap");
        in4 = 4'h5;
        repeat (3) tick();
        wr(0, 3'd3, 32'h5);
        rd(0, 3'd3, 32'h1, "race_cap");
        check("race_irq", {31'd0, irq4}, 32'd1);
        wr(0, 3'd3, 32'h1);
        check("race_irq_clr", {31'd0, irq4}, 32'd0);

        // masking on bit 3
        wr(0, 3'd2, 32'h0);
        wr(0, 3'd1, 32'hD);
        in4 = 4'hD;
        repeat (6) tick();
        check("mask_irq_off", {31'd0, irq4}, 32'd0);
        rd(0, 3'd3, 32'h8, "mask_cap");
        wr(0, 3'd2, 32'h8);
        check("mask_irq_on", {31'd0, irq4}, 32'd1);

        // async reset mid-debounce with a capture pending; input stays high across release
        wr(0, 3'd5, 32'd10);
        in4 = 4'hF;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq4}, 32'd0);
        check("rst_readdata", rd4, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        rd(0, 3'd1, 32'h0, "rst_rise_en");
        rd(0, 3'd2, 32'h0, "rst_mask");
        rd(0, 3'd3, 32'h0, "rst_cap");
        rd(0, 3'd4, 32'h0, "rst_fall_en");
        rd(0, 3'd5, 32'h0, "rst_deb");
        repeat (10) tick();
        rd(0, 3'd0, 32'hF, "rst_rel_data");
        rd(0, 3'd3, 32'h0, "rst_rel_no_cap");
        check("rst_rel_irq", {31'd0, irq4}, 32'd0);

        // WIDTH=32 on bit 31
        rd(1, 3'd5, 32'd5, "w32_deb_rst");
        wr(1, 3'd5, 32'd0);
        wr(1, 3'd1, 32'h8000_0000);
        wr(1, 3'd2, 32'h8000_0000);
        in32 = 32'h8000_0000;
        repeat (3) tick();
        check("w32_irq_early", {31'd0, irq32}, 32'd0);
        tick();
        check("w32_irq", {31'd0, irq32}, 32'd1);
        rd(1, 3'd3, 32'h8000_0000, "w32_cap");
        rd(1, 3'd0, 32'h8000_0000, "w32_data");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
